pe_addc: RTL and testbench

- Parametrised successor to the fixed add-one PE: NCH independent lanes, each computing Q = D + ADDEND on W-bit words.
- Each lane has selectable wrap or saturate arithmetic, a two-register elastic stage with per-lane backpressure, and per-lane frame-start (Q_SOF) generation from a programmable frame length.
- Sits between a stream source and sink in the PE chain; each lane's streams are flattened onto buses.

---
 rtl/pe_addc.sv | 110 +++++++++++
 tb/tb_pe_addc.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_addc.sv
// pe_addc: NCH independent lanes computing Q = D + ADDEND (wrap or saturate),
// each with a two-register elastic stage and frame-start generation.
module pe_addc #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 64,
    parameter int unsigned LW  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH*W-1:0] D,
    input  logic [NCH-1:0]   D_VALID,
    output logic [NCH-1:0]   D_BP,
    input  logic [W-1:0]     ADDEND,
    input  logic             SAT,
    input  logic [LW-1:0]    FRAME_LEN,
    output logic [NCH*W-1:0] Q,
    output logic [NCH-1:0]   Q_VALID,
    input  logic [NCH-1:0]   Q_BP,
    output logic [NCH-1:0]   Q_SOF
);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        logic [W-1:0]  or_d, or_d_nx;
        logic          or_v, or_v_nx;
        logic          or_sof, or_sof_nx;
        logic [W-1:0]  sr_d, sr_d_nx;
        logic          sr_v, sr_v_nx;
        logic [LW-1:0] cnt, cnt_nx;
        logic [LW-1:0] len, len_nx;
        logic [W:0]    sum_c;
        logic [W-1:0]  res_c;
        logic [W-1:0]  load_d;
        logic          load;
        logic          in_xfer;
        logic          out_xfer;

        // Next-state: arithmetic, OR/SR steering and frame counting.
        always_comb begin
            sum_c     = {1'b0, D[i*W +: W]} + {1'b0, ADDEND};
            res_c     = (SAT && sum_c[W]) ? {W{1'b1}} : sum_c[W-1:0];
            in_xfer   = D_VALID[i] && !sr_v;
            out_xfer  = or_v && !Q_BP[i];
            or_d_nx   = or_d;
            or_v_nx   = or_v;
            or_sof_nx = or_sof;
            sr_d_nx   = sr_d;
            sr_v_nx   = sr_v;
            cnt_nx    = cnt;
            len_nx    = len;
            load      = 1'b0;
            load_d    = res_c;

            // Counter indexes the word currently in OR; len is fixed per frame.
            if (out_xfer && (len != '0)) begin
                cnt_nx = (cnt == len - LW'(1)) ? '0 : cnt + LW'(1);
            end

            if (!or_v || out_xfer) begin
                if (sr_v) begin
                    load    = 1'b1;
                    load_d  = sr_d;
                    sr_v_nx = 1'b0;
                end else if (in_xfer) begin
                    load = 1'b1;
                end
                or_v_nx   = load;
                or_sof_nx = 1'b0;
            end else if (in_xfer) begin
                sr_v_nx = 1'b1;
                sr_d_nx = res_c;
            end

            // A word entering OR at count 0 opens a frame and latches its length.
            if (load) begin
                or_d_nx = load_d;
                if (cnt_nx == '0) begin
                    len_nx    = FRAME_LEN;
                    or_sof_nx = (FRAME_LEN != '0);
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                or_d   <= '0;
                or_v   <= 1'b0;
                or_sof <= 1'b0;
                sr_d   <= '0;
                sr_v   <= 1'b0;
                cnt    <= '0;
                len    <= '0;
            end else begin
                or_d   <= or_d_nx;
                or_v   <= or_v_nx;
                or_sof <= or_sof_nx;
                sr_d   <= sr_d_nx;
                sr_v   <= sr_v_nx;
                cnt    <= cnt_nx;
                len    <= len_nx;
            end
        end

        // Backpressure is exactly skid-register occupancy.
        assign D_BP[i]       = sr_v;
        assign Q[i*W +: W]   = or_d;
        assign Q_VALID[i]    = or_v;
        assign Q_SOF[i]      = or_sof;
    end

endmodule

// File: tb/tb_pe_addc.sv
// Scoreboard bench for pe_addc: drivers push expected words per lane,
// a negedge monitor pops and compares on every output transfer.
module tb_pe_addc;
    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 64;
    localparam int unsigned LW  = 16;

    logic             clk;
    logic             rst;
    logic [NCH*W-1:0] d;
    logic [NCH-1:0]   d_valid;
    logic [NCH-1:0]   d_bp;
    logic [W-1:0]     addend;
    logic             sat;
    logic [LW-1:0]    frame_len;
    logic [NCH*W-1:0] q;
    logic [NCH-1:0]   q_valid;
    logic [NCH-1:0]   q_bp;
    logic [NCH-1:0]   q_sof;

    logic [W-1:0]     d_l [NCH];
    logic             dv_l [NCH];
    logic [NCH-1:0]   hold_mask;
    logic             rand_en;
    logic [W-1:0]     ones;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sof;
    } exp_t;

    exp_t sb [NCH][$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    logic         hold_p [NCH];
    logic [W-1:0] hold_q [NCH];
    logic         hold_s [NCH];
    logic         fill_p [NCH];
    logic         dbp_p  [NCH];

    pe_addc #(.NCH(NCH), .W(W), .LW(LW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .D         (d),
        .D_VALID   (d_valid),
        .D_BP      (d_bp),
        .ADDEND    (addend),
        .SAT       (sat),
        .FRAME_LEN (frame_len),
        .Q         (q),
        .Q_VALID   (q_valid),
        .Q_BP      (q_bp),
        .Q_SOF     (q_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        d       = '0;
        d_valid = '0;
        for (int l = 0; l < NCH; l++) begin
            d[l*W +: W] = d_l[l];
            d_valid[l]  = dv_l[l];
        end
    end

    // Sink backpressure: held lanes plus optional ~30% random on lane 1.
    always begin
        @(posedge clk);
        #1;
        q_bp = hold_mask | ((rand_en && ($urandom_range(0, 9) < 3)) ? NCH'(2) : NCH'(0));
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Must be entered between a rising edge and the following falling edge.
    task automatic send(input int l, input logic [W-1:0] data, input logic [W-1:0] exp_d,
                        input logic exp_sof);
        int   n;
        exp_t e;
        n = 0;
        d_l[l]  = data;
        dv_l[l] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (!d_bp[l]) begin
                e.d   = exp_d;
                e.sof = exp_sof;
                sb[l].push_back(e);
                break;
            end
            n++;
            if (n > 2000) begin
                total++;
                bad++;
                $display("FAIL send_timeout lane%0d: D_BP stuck at 1, want 0", l);
                break;
            end
        end
        @(posedge clk);
        #1;
        dv_l[l] = 1'b0;
    endtask

    task automatic stream(input int l, input int n, input logic [W-1:0] base);
        for (int k = 0; k < n; k++) begin
            send(l, base + W'(k), base + W'(k) + addend, 1'b0);
        end
    endtask

    task automatic wait_drain();
        int  n;
        logic empty;
        n = 0;
        while (1) begin
            @(negedge clk);
            empty = (q_valid == '0);
            for (int l = 0; l < NCH; l++) if (sb[l].size() != 0) empty = 1'b0;
            if (empty) break;
            n++;
            if (n > 3000) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: q_valid=%b still pending, want all drained", q_valid);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: output transfers vs scoreboard, hold stability, D_BP rise cause.
    always @(negedge clk) begin
        for (int l = 0; l < NCH; l++) begin
            if (rst) begin
                hold_p[l] = 1'b0;
                fill_p[l] = 1'b0;
                dbp_p[l]  = 1'b0;
            end else begin
                if (hold_p[l]) begin
                    total++;
                    if (!q_valid[l] || q[l*W +: W] !== hold_q[l] || q_sof[l] !== hold_s[l]) begin
                        bad++;
                        $display("FAIL hold lane%0d: got v=%b q=%h sof=%b want v=1 q=%h sof=%b",
                                 l, q_valid[l], q[l*W +: W], q_sof[l], hold_q[l], hold_s[l]);
                    end
                end
                if (d_bp[l] && !dbp_p[l]) begin
                    total++;
                    if (!fill_p[l]) begin
                        bad++;
                        $display("FAIL dbp_rise lane%0d: got D_BP=1 without skid fill, want 0", l);
                    end
                end
                if (q_valid[l] && !q_bp[l]) begin
                    total++;
                    if (sb[l].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected lane%0d: got q=%h, want no word", l, q[l*W +: W]);
                    end else begin
                        mon_e = sb[l].pop_front();
                        if (q[l*W +: W] !== mon_e.d || q_sof[l] !== mon_e.sof) begin
                            bad++;
                            $display("FAIL out lane%0d: got q=%h sof=%b want q=%h sof=%b",
                                     l, q[l*W +: W], q_sof[l], mon_e.d, mon_e.sof);
                        end
                    end
                end
                hold_p[l] = q_valid[l] && q_bp[l];
                hold_q[l] = q[l*W +: W];
                hold_s[l] = q_sof[l];
                fill_p[l] = dv_l[l] && !d_bp[l] && q_valid[l] && q_bp[l];
                dbp_p[l]  = d_bp[l];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, want completion");
        $fatal(1, "watchdog");
    end

    longint t0;
    longint t_done [3];
    logic [W-1:0] data;
    logic [W-1:0] expv;

    initial begin
        rst       = 1'b1;
        sat       = 1'b0;
        addend    = '0;
        frame_len = '0;
        hold_mask = '0;
        rand_en   = 1'b0;
        ones      = '1;
        for (int l = 0; l < NCH; l++) begin
            d_l[l]  = '0;
            dv_l[l] = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_qvalid", W'(q_valid), '0);
        chk("rst_dbp", W'(d_bp), '0);
        chk("rst_sof", W'(q_sof), '0);
        chk("rst_q", W'(|q), '0);
        @(posedge clk);
        #1;

        // Basic add with one-cycle latency.
        addend = 64'd1;
        sat    = 1'b0;
        send(0, 64'h0100_0000_0000_0004, 64'h0100_0000_0000_0005, 1'b0);
        @(negedge clk);
        chk("basic_q", q[63:0], 64'h0100_0000_0000_0005);
        chk("basic_valid", W'(q_valid), W'(4'b0001));
        @(posedge clk);
        #1;

        // Wrap vs saturate.
        addend = 64'd2;
        sat    = 1'b0;
        send(0, ones, 64'h1, 1'b0);
        sat = 1'b1;
        send(0, ones, ones, 1'b0);
        for (int k = 0; k < 20; k++) begin
            sat  = (k % 2) == 1;
            data = ~W'(k);
            if (k == 0)      expv = 64'h1;
            else if (k == 1) expv = ones;
            else             expv = data + 64'd2;
            send(0, data, expv, 1'b0);
        end
        wait_drain();

        // Lane 1 burst under random backpressure.
        addend  = 64'd3;
        sat     = 1'b0;
        rand_en = 1'b1;
        stream(1, 500, 64'h1000);
        rand_en = 1'b0;
        wait_drain();

        // All lanes concurrently; lane 3 stalled for 100 cycles.
        addend    = 64'd5;
        hold_mask = 4'b1000;
        t0 = $time;
        fork
            begin stream(0, 500, 64'h2000); t_done[0] = $time; end
            begin stream(1, 500, 64'h3000); t_done[1] = $time; end
            begin stream(2, 500, 64'h4000); t_done[2] = $time; end
            stream(3, 500, 64'h5000);
            begin
                repeat (100) @(posedge clk);
                #2;
                chk("stall_dbp3", W'(d_bp[3]), W'(1'b1));
                chk("stall_qvalid3", W'(q_valid[3]), W'(1'b1));
                hold_mask = '0;
            end
        join
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("full_rate_lane%0d", l), W'(((t_done[l] - t0) / 10) <= 501), W'(1'b1));
        end
        wait_drain();

        // Framing on lane 2.
        addend    = 64'd1;
        frame_len = '0;
        for (int k = 0; k < 10; k++) send(2, W'(k), W'(k + 1), 1'b0);
        frame_len = 16'd4;
        for (int k = 0; k < 12; k++) send(2, W'(k), W'(k + 1), (k == 0) || (k == 4) || (k == 8));
        for (int k = 0; k < 14; k++) begin
            if (k == 5)  frame_len = 16'd3;
            if (k == 12) frame_len = 16'd0;
            send(2, W'(k), W'(k + 1), (k == 0) || (k == 4) || (k == 8) || (k == 11));
        end
        wait_drain();

        // Reset with both registers full on every lane.
        frame_len = 16'd4;
        hold_mask = '1;
        @(posedge clk);
        #2;
        fork
            begin send(0, 64'h10, 64'h11, 1'b1); send(0, 64'h20, 64'h21, 1'b0); end
            begin send(1, 64'h10, 64'h11, 1'b1); send(1, 64'h20, 64'h21, 1'b0); end
            begin send(2, 64'h10, 64'h11, 1'b1); send(2, 64'h20, 64'h21, 1'b0); end
            begin send(3, 64'h10, 64'h11, 1'b1); send(3, 64'h20, 64'h21, 1'b0); end
        join
        chk("full_dbp", W'(d_bp), W'(4'hF));
        chk("full_qvalid", W'(q_valid), W'(4'hF));
        rst = 1'b1;
        for (int l = 0; l < NCH; l++) sb[l].delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        hold_mask = '0;
        @(negedge clk);
        chk("midrst_qvalid", W'(q_valid), '0);
        chk("midrst_dbp", W'(d_bp), '0);
        chk("midrst_sof", W'(q_sof), '0);
        @(posedge clk);
        #2;
        send(0, 64'h77, 64'h78, 1'b1);
        send(0, 64'h78, 64'h79, 1'b0);
        send(3, 64'h90, 64'h91, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
